// File: rtl/tqvp_bus_initiator.sv
// ---------------------------------------------------------------------------
// tqvp_bus_initiator
//
// Turns single-access commands from a host-side source (debug bridge or
// testbench) into TinyQV peripheral bus cycles on one peripheral slot. It
// returns one response per command and counts rising edges of the
// peripheral's interrupt line.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_write             1 = write, 0 = read
//   cmd_size              00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = illegal
//   cmd_addr, cmd_wdata   peripheral address and write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata, rsp_err    zero-extended read data, error flag
//   per_address/per_wdata peripheral address / data_in (registered)
//   per_write_n/per_read_n peripheral strobes, 11 = idle (registered)
//   per_rdata/per_ready   peripheral data_out / data_ready
//   per_irq               peripheral user_interrupt
//   irq_rise, irq_count   edge pulse and wrapping 8-bit edge counter
// ---------------------------------------------------------------------------
module tqvp_bus_initiator #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_size,
    input  logic [5:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [5:0]  per_address,
    output logic [31:0] per_wdata,
    output logic [1:0]  per_write_n,
    output logic [1:0]  per_read_n,
    input  logic [31:0] per_rdata,
    input  logic        per_ready,
    input  logic        per_irq,
    output logic        irq_rise,
    output logic [7:0]  irq_count
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [1:0]        size_q, size_d;
    logic [5:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic [1:0]        write_n_q, write_n_d;
    logic [1:0]        read_n_q, read_n_d;

    logic              irq_last_q;
    logic              irq_rise_q;
    logic [7:0]        irq_count_q;
    logic              irq_edge;

    function automatic logic [31:0] size_extend(input logic [31:0] d,
                                                input logic [1:0]  s);
        logic [31:0] r;
        case (s)
            2'b00:   r = {24'h0, d[7:0]};
            2'b01:   r = {16'h0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    assign cnt_inc = cnt_q + CNT_ONE;

    // Strobes are computed as next-state values so they leave a flop, which
    // puts the strobe one cycle after acceptance and drops it on the same
    // edge that moves the state out of ACCESS.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        write_n_d = 2'b11;
        read_n_d  = 2'b11;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    write_d = cmd_write;
                    size_d  = cmd_size;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    rdata_d = 32'h0;
                    cnt_d   = '0;
                    if (cmd_size == 2'b11) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ACCESS;
                        if (cmd_write) write_n_d = cmd_size;
                        else           read_n_d  = cmd_size;
                    end
                end
            end

            S_ACCESS: begin
                if (write_q) begin
                    // Writes complete unconditionally; per_ready is ignored.
                    state_d = S_RESP;
                end else if (per_ready) begin
                    // Ready wins even on the cycle the wait counter expires.
                    rdata_d = size_extend(per_rdata, size_q);
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        read_n_d = size_q;
                    end
                end
            end

            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            write_q   <= 1'b0;
            size_q    <= 2'b00;
            addr_q    <= 6'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            write_n_q <= 2'b11;
            read_n_q  <= 2'b11;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            write_n_q <= write_n_d;
            read_n_q  <= read_n_d;
        end
    end

    // Interrupt edge detector runs independently of the command FSM.
    assign irq_edge = per_irq & ~irq_last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_last_q  <= 1'b0;
            irq_rise_q  <= 1'b0;
            irq_count_q <= 8'h0;
        end else begin
            irq_last_q  <= per_irq;
            irq_rise_q  <= irq_edge;
            irq_count_q <= irq_count_q + {7'h0, irq_edge};
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign per_address = addr_q;
    assign per_wdata   = wdata_q;
    assign per_write_n = write_n_q;
    assign per_read_n  = read_n_q;
    assign irq_rise    = irq_rise_q;
    assign irq_count   = irq_count_q;

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_tqvp_bus_initiator
//
// Self-checking bench for tqvp_bus_initiator (TIMEOUT = 16). A table of
// command records drives single accesses and compares strobe count, strobe
// contents, response latency and response data; hand-written sequences cover
// reset, backpressure, throughput, interrupt counting and wrap.
// ---------------------------------------------------------------------------
module tb_tqvp_bus_initiator;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [1:0]  cmd_size;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  per_address;
    logic [31:0] per_wdata;
    logic [1:0]  per_write_n;
    logic [1:0]  per_read_n;
    logic [31:0] per_rdata;
    logic        per_ready;
    logic        per_irq;
    logic        irq_rise;
    logic [7:0]  irq_count;

    int checks = 0;
    int errors = 0;
    int rises  = 0;

    tqvp_bus_initiator #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_size    (cmd_size),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .per_address (per_address),
        .per_wdata   (per_wdata),
        .per_write_n (per_write_n),
        .per_read_n  (per_read_n),
        .per_rdata   (per_rdata),
        .per_ready   (per_ready),
        .per_irq     (per_irq),
        .irq_rise    (irq_rise),
        .irq_count   (irq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

    // rdy_at: ACCESS cycle (1-based) in which per_ready is high, 0 = never.
    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          rdy_at;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_strb;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        int strb;
        logic bad;
        lat  = -1;
        strb = 0;
        bad  = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_cmd_ready", idx), {31'h0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_size  = v.size;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        per_rdata = v.prdata;
        per_ready = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (per_write_n !== 2'b11 || per_read_n !== 2'b11) begin
                strb++;
                if (v.wr) begin
                    if (per_write_n !== v.size || per_read_n !== 2'b11) bad = 1'b1;
                end else begin
                    if (per_read_n !== v.size || per_write_n !== 2'b11) bad = 1'b1;
                end
                if (per_address !== v.addr || per_wdata !== v.wdata) bad = 1'b1;
            end
            if (rsp_valid) lat = c;
            per_ready = (v.rdy_at != 0) && (c == v.rdy_at);
        end
        per_ready = 1'b0;
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_strobe_cycles", idx), strb, v.exp_strb);
        chk($sformatf("v%0d_strobe_content", idx), {31'h0, bad}, 32'h0);
        chk($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
        chk($sformatf("v%0d_rsp_err", idx), {31'h0, rsp_err}, {31'h0, v.exp_err});
        chk($sformatf("v%0d_per_address", idx), {26'h0, per_address}, {26'h0, v.addr});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_rsp_valid_after", idx), {31'h0, rsp_valid}, 32'h0);
        chk($sformatf("v%0d_cmd_ready_after", idx), {31'h0, cmd_ready}, 32'h1);
    endtask

    // Samples irq_rise at a falling edge, then drives the next per_irq level.
    task automatic irq_cycle(input logic lvl);
        @(negedge clk);
        if (irq_rise === 1'b1) rises++;
        per_irq = lvl;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cmd_ready"},   {31'h0, cmd_ready},   32'h1);
        chk({tag, "_rsp_valid"},   {31'h0, rsp_valid},   32'h0);
        chk({tag, "_rsp_rdata"},   rsp_rdata,            32'h0);
        chk({tag, "_rsp_err"},     {31'h0, rsp_err},     32'h0);
        chk({tag, "_per_write_n"}, {30'h0, per_write_n}, 32'h3);
        chk({tag, "_per_read_n"},  {30'h0, per_read_n},  32'h3);
        chk({tag, "_per_address"}, {26'h0, per_address}, 32'h0);
        chk({tag, "_per_wdata"},   per_wdata,            32'h0);
        chk({tag, "_irq_rise"},    {31'h0, irq_rise},    32'h0);
        chk({tag, "_irq_count"},   {24'h0, irq_count},   32'h0);
    endtask

    initial begin
        int acc;

        //            wr    size   addr   wdata         prdata        rdy  exp_rdata     err  lat strb
        vecs[0] = '{1'b1, 2'b10, 6'h00, 32'hDEADBEEF, 32'h0,        0,  32'h0,        1'b0, 2,  1};
        vecs[1] = '{1'b0, 2'b00, 6'h04, 32'h0,        32'h12345678, 1,  32'h00000078, 1'b0, 2,  1};
        vecs[2] = '{1'b0, 2'b01, 6'h08, 32'h0,        32'hAABBCCDD, 4,  32'h0000CCDD, 1'b0, 5,  4};
        vecs[3] = '{1'b0, 2'b10, 6'h3F, 32'h0,        32'hCAFEF00D, 1,  32'hCAFEF00D, 1'b0, 2,  1};
        vecs[4] = '{1'b0, 2'b10, 6'h0C, 32'h0,        32'hFFFFFFFF, 0,  32'h0,        1'b1, 17, 16};
        vecs[5] = '{1'b0, 2'b00, 6'h10, 32'h0,        32'h123456A5, 16, 32'h000000A5, 1'b0, 17, 16};
        vecs[6] = '{1'b0, 2'b11, 6'h05, 32'h0,        32'h55555555, 1,  32'h0,        1'b1, 1,  0};
        vecs[7] = '{1'b1, 2'b00, 6'h2A, 32'h00000011, 32'hFFFFFFFF, 1,  32'h0,        1'b0, 2,  1};
        vecs[8] = '{1'b1, 2'b01, 6'h15, 32'h0000BEEF, 32'h0,        0,  32'h0,        1'b0, 2,  1};

        rst_n     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_size  = 2'b00;
        cmd_addr  = 6'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        per_rdata = 32'h0;
        per_ready = 1'b0;
        per_irq   = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Backpressure: response held for 5 cycles, new command refused.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_size  = 2'b10;
        cmd_addr  = 6'h10;
        per_rdata = 32'h87654321;
        per_ready = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        per_ready = 1'b0;
        chk("bp_rsp_valid_first", {31'h0, rsp_valid}, 32'h1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_size  = 2'b00;
        cmd_addr  = 6'h33;
        cmd_wdata = 32'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_rsp_valid", i), {31'h0, rsp_valid}, 32'h1);
            chk($sformatf("bp%0d_rsp_rdata", i), rsp_rdata, 32'h87654321);
            chk($sformatf("bp%0d_rsp_err", i), {31'h0, rsp_err}, 32'h0);
            chk($sformatf("bp%0d_cmd_ready", i), {31'h0, cmd_ready}, 32'h0);
            chk($sformatf("bp%0d_per_write_n", i), {30'h0, per_write_n}, 32'h3);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_addr_not_reloaded", {26'h0, per_address}, 32'h10);
        chk("bp_cmd_ready_after", {31'h0, cmd_ready}, 32'h1);

        // Throughput: writes back to back with rsp_ready high.
        acc = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_size  = 2'b10;
        cmd_addr  = 6'h01;
        cmd_wdata = 32'h01020304;
        rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c != 0) @(negedge clk);
            if (cmd_ready === 1'b1) acc++;
            if (c == 11) cmd_valid = 1'b0;
        end
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
        chk("tput_accepts_in_12", acc, 4);
        chk("tput_idle_after", {31'h0, cmd_ready}, 32'h1);

        // Interrupts: three pulses, then a long high level.
        rises = 0;
        for (int i = 0; i < 3; i++) begin
            irq_cycle(1'b1);
            irq_cycle(1'b0);
        end
        chk("irq_three_pulses", rises, 3);
        chk("irq_count_three", {24'h0, irq_count}, 32'h3);
        for (int i = 0; i < 10; i++) irq_cycle(1'b1);
        irq_cycle(1'b0);
        irq_cycle(1'b0);
        chk("irq_held_pulses", rises, 4);
        chk("irq_count_four", {24'h0, irq_count}, 32'h4);

        // Reset asserted in the middle of a waiting read.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_size  = 2'b01;
        cmd_addr  = 6'h21;
        cmd_wdata = 32'hA5A5A5A5;
        per_ready = 1'b0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midread_strobe", {30'h0, per_read_n}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_reset_state("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap after 256 edges from reset.
        for (int i = 0; i < 255; i++) begin
            irq_cycle(1'b1);
            irq_cycle(1'b0);
        end
        chk("irq_count_255", {24'h0, irq_count}, 32'hFF);
        irq_cycle(1'b1);
        irq_cycle(1'b0);
        chk("irq_count_wrap", {24'h0, irq_count}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
